// File: rtl/ifu_fetch_ctrl.sv
// Instruction fetch controller: issues one word-aligned fetch at a time,
// waits for the response (bounded by a timeout), hands the instruction to
// decode, then waits for the next PC from writeback.
module ifu_fetch_ctrl #(
  parameter int              XLEN    = 32,
  parameter logic [XLEN-1:0] PC_RST  = 32'h8000_0000,
  parameter int              TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            imem_resp_err,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  output logic            out_fault,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2,
    S_NEXT = 2'd3
  } state_t;

  localparam logic [7:0]      TO_LIMIT = 8'(TIMEOUT);
  localparam logic [XLEN-1:0] NOP_INSN = XLEN'(32'h0000_0013);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic [7:0]      r_cnt;
  logic [7:0]      w_cnt_nxt;
  logic [7:0]      w_cnt_inc;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] w_instr_nxt;
  logic            r_fault;
  logic            w_fault_nxt;
  logic            r_req_valid;
  logic            r_out_valid;
  logic            w_timeout;

  // Timeout fires on the WAIT cycle whose count would reach the limit,
  // and only when no response is present (a response always wins).
  assign w_cnt_inc = r_cnt + 8'd1;
  assign w_timeout = (r_state == S_WAIT) && !imem_resp_valid && (w_cnt_inc == TO_LIMIT);

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; inputs not relevant to the current state are ignored.
  always_comb begin
    w_state_nxt = S_REQ;
    case (r_state)
      S_REQ:   w_state_nxt = imem_req_ready ? S_WAIT : S_REQ;
      S_WAIT: begin
        if (imem_resp_valid || w_timeout) begin
          w_state_nxt = S_OUT;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_OUT:   w_state_nxt = out_ready ? S_NEXT : S_OUT;
      S_NEXT:  w_state_nxt = upd_valid ? S_REQ : S_NEXT;
      default: w_state_nxt = S_REQ;
    endcase
  end

  // Datapath next values: PC update, wait counter, captured instruction/fault.
  always_comb begin
    w_pc_nxt    = r_pc;
    w_cnt_nxt   = r_cnt;
    w_instr_nxt = r_instr;
    w_fault_nxt = r_fault;
    case (r_state)
      S_REQ: begin
        if (imem_req_ready) begin
          w_cnt_nxt = 8'd0;
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          w_instr_nxt = imem_resp_data;
          w_fault_nxt = imem_resp_err;
        end else if (w_timeout) begin
          w_instr_nxt = NOP_INSN;
          w_fault_nxt = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_NEXT: begin
        if (upd_valid) begin
          w_pc_nxt = upd_pc;
        end else begin
          w_pc_nxt = r_pc;
        end
      end
      default: begin
        w_pc_nxt = r_pc;
      end
    endcase
  end

  // Datapath and handshake output registers; valids follow the next state
  // so they are registered and mutually exclusive by construction.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc        <= PC_RST;
      r_cnt       <= 8'd0;
      r_instr     <= '0;
      r_fault     <= 1'b0;
      r_req_valid <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_pc        <= w_pc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_instr     <= w_instr_nxt;
      r_fault     <= w_fault_nxt;
      r_req_valid <= (w_state_nxt == S_REQ);
      r_out_valid <= (w_state_nxt == S_OUT);
    end
  end

  assign imem_req_valid = r_req_valid;
  assign imem_req_addr  = {r_pc[XLEN-1:2], 2'b00};
  assign out_valid      = r_out_valid;
  assign out_pc         = r_pc;
  assign out_instr      = r_instr;
  assign out_fault      = r_fault;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed self-checking bench for ifu_fetch_ctrl.
module tb_ifu_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_fault;
  logic        upd_valid;
  logic [31:0] upd_pc;

  int checks;
  int errors;

  ifu_fetch_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .imem_resp_err   (imem_resp_err),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_instr       (out_instr),
    .out_fault       (out_fault),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time bound so the run can never hang.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    imem_resp_err   = 1'b0;
    out_ready       = 1'b0;
    upd_valid       = 1'b0;
    upd_pc          = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 5;
    if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL rst_req_valid got %b exp 1", imem_req_valid); end
    if (imem_req_addr !== 32'h8000_0000) begin errors++; $display("FAIL rst_addr got %h exp 80000000", imem_req_addr); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    if (out_instr !== 32'h0) begin errors++; $display("FAIL rst_out_instr got %h exp 0", out_instr); end
    if (out_fault !== 1'b0) begin errors++; $display("FAIL rst_out_fault got %b exp 0", out_fault); end
  endtask

  task automatic test_basic_fetch();
    do_reset();
    imem_req_ready = 1'b1;
    tick();                               // request accepted -> WAIT
    imem_req_ready = 1'b0;
    checks += 2;
    if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL basic_wait_req got %b exp 0", imem_req_valid); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_wait_out got %b exp 0", out_valid); end
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0010_0093;
    tick();                               // response -> OUT
    imem_resp_valid = 1'b0;
    checks += 5;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid got %b exp 1", out_valid); end
    if (out_pc !== 32'h8000_0000) begin errors++; $display("FAIL basic_out_pc got %h exp 80000000", out_pc); end
    if (out_instr !== 32'h0010_0093) begin errors++; $display("FAIL basic_out_instr got %h exp 00100093", out_instr); end
    if (out_fault !== 1'b0) begin errors++; $display("FAIL basic_out_fault got %b exp 0", out_fault); end
    if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL basic_excl got %b exp 0", imem_req_valid); end
    out_ready = 1'b1;
    tick();                               // -> NEXT
    out_ready = 1'b0;
    checks += 1;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_next_out got %b exp 0", out_valid); end
    upd_valid = 1'b1;
    upd_pc    = 32'h8000_0004;
    tick();                               // -> REQ
    upd_valid = 1'b0;
    checks += 2;
    if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL basic_req2_valid got %b exp 1", imem_req_valid); end
    if (imem_req_addr !== 32'h8000_0004) begin errors++; $display("FAIL basic_req2_addr got %h exp 80000004", imem_req_addr); end
  endtask

  task automatic test_req_stall();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks += 2;
      if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL stall_req_valid cyc %0d got %b exp 1", i, imem_req_valid); end
      if (imem_req_addr !== 32'h8000_0000) begin errors++; $display("FAIL stall_req_addr cyc %0d got %h exp 80000000", i, imem_req_addr); end
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks += 1;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_wait_out cyc %0d got %b exp 0", i, out_valid); end
    end
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    tick();
    imem_resp_valid = 1'b0;
    checks += 3;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid got %b exp 1", out_valid); end
    if (out_instr !== 32'hDEAD_BEEF) begin errors++; $display("FAIL stall_out_instr got %h exp deadbeef", out_instr); end
    if (out_fault !== 1'b0) begin errors++; $display("FAIL stall_out_fault got %b exp 0", out_fault); end
  endtask

  task automatic test_out_stall();
    do_reset();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h1234_5678;
    tick();                               // in OUT
    for (int i = 0; i < 4; i++) begin
      upd_valid       = 1'b1;
      upd_pc          = $urandom;
      imem_resp_valid = 1'b1;
      imem_resp_data  = $urandom;
      imem_resp_err   = 1'b1;
      tick();
      checks += 5;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL ostall_valid cyc %0d got %b exp 1", i, out_valid); end
      if (out_pc !== 32'h8000_0000) begin errors++; $display("FAIL ostall_pc cyc %0d got %h exp 80000000", i, out_pc); end
      if (out_instr !== 32'h1234_5678) begin errors++; $display("FAIL ostall_instr cyc %0d got %h exp 12345678", i, out_instr); end
      if (out_fault !== 1'b0) begin errors++; $display("FAIL ostall_fault cyc %0d got %b exp 0", i, out_fault); end
      if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL ostall_req cyc %0d got %b exp 0", i, imem_req_valid); end
    end
    idle_inputs();
    out_ready = 1'b1;
    tick();                               // -> NEXT
    // Stay in NEXT with stray out_ready/resp_valid
    imem_resp_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks += 2;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL next_hold_out cyc %0d got %b exp 0", i, out_valid); end
      if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL next_hold_req cyc %0d got %b exp 0", i, imem_req_valid); end
    end
    idle_inputs();
    upd_valid = 1'b1;
    upd_pc    = 32'h8000_0010;
    tick();
    upd_valid = 1'b0;
    checks += 2;
    if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL ostall_req2_valid got %b exp 1", imem_req_valid); end
    if (imem_req_addr !== 32'h8000_0010) begin errors++; $display("FAIL ostall_req2_addr got %h exp 80000010", imem_req_addr); end
  endtask

  task automatic test_timeout();
    bit early;
    do_reset();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    early = 1'b0;
    for (int i = 0; i < 254; i++) begin
      tick();
      if (out_valid !== 1'b0) early = 1'b1;
    end
    checks += 1;
    if (early !== 1'b0) begin errors++; $display("FAIL to_early got out_valid before 255 wait cycles exp none"); end
    tick();
    checks += 4;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL to_out_valid got %b exp 1", out_valid); end
    if (out_instr !== 32'h0000_0013) begin errors++; $display("FAIL to_out_instr got %h exp 00000013", out_instr); end
    if (out_fault !== 1'b1) begin errors++; $display("FAIL to_out_fault got %b exp 1", out_fault); end
    if (out_pc !== 32'h8000_0000) begin errors++; $display("FAIL to_out_pc got %h exp 80000000", out_pc); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    upd_valid = 1'b1;
    upd_pc    = 32'h8000_0008;
    tick();
    upd_valid      = 1'b0;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 254; i++) tick();
    // Response with error arrives in the very cycle the timeout would fire.
    imem_resp_valid = 1'b1;
    imem_resp_err   = 1'b1;
    imem_resp_data  = 32'hCAFE_F00D;
    tick();
    idle_inputs();
    checks += 4;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL err_out_valid got %b exp 1", out_valid); end
    if (out_instr !== 32'hCAFE_F00D) begin errors++; $display("FAIL err_out_instr got %h exp cafef00d", out_instr); end
    if (out_fault !== 1'b1) begin errors++; $display("FAIL err_out_fault got %b exp 1", out_fault); end
    if (out_pc !== 32'h8000_0008) begin errors++; $display("FAIL err_out_pc got %h exp 80000008", out_pc); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    imem_req_ready = 1'b1;
    tick();                               // in WAIT
    imem_req_ready = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks += 3;
    if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL rwait_req got %b exp 1", imem_req_valid); end
    if (imem_req_addr !== 32'h8000_0000) begin errors++; $display("FAIL rwait_addr got %h exp 80000000", imem_req_addr); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rwait_out got %b exp 0", out_valid); end
    // Move pc away from reset value, then reset while in OUT.
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0000_1111;
    tick();
    imem_resp_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    upd_valid = 1'b1;
    upd_pc    = 32'h8000_0020;
    tick();
    upd_valid      = 1'b0;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0000_2222;
    tick();                               // in OUT at 0x80000020
    imem_resp_valid = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks += 5;
    if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL rout_req got %b exp 1", imem_req_valid); end
    if (imem_req_addr !== 32'h8000_0000) begin errors++; $display("FAIL rout_addr got %h exp 80000000", imem_req_addr); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rout_out got %b exp 0", out_valid); end
    if (out_instr !== 32'h0) begin errors++; $display("FAIL rout_instr got %h exp 0", out_instr); end
    if (out_fault !== 1'b0) begin errors++; $display("FAIL rout_fault got %b exp 0", out_fault); end
  endtask

  task automatic test_misaligned();
    do_reset();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0000_0033;
    tick();
    imem_resp_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    upd_valid = 1'b1;
    upd_pc    = 32'h8000_0006;
    tick();
    upd_valid = 1'b0;
    checks += 1;
    if (imem_req_addr !== 32'h8000_0004) begin errors++; $display("FAIL mis_addr got %h exp 80000004", imem_req_addr); end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0000_0073;
    tick();
    imem_resp_valid = 1'b0;
    checks += 3;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL mis_out_valid got %b exp 1", out_valid); end
    if (out_pc !== 32'h8000_0006) begin errors++; $display("FAIL mis_out_pc got %h exp 80000006", out_pc); end
    if (out_instr !== 32'h0000_0073) begin errors++; $display("FAIL mis_out_instr got %h exp 00000073", out_instr); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    idle_inputs();
    test_reset();
    test_basic_fetch();
    test_req_stall();
    test_out_stall();
    test_timeout();
    test_reset_mid();
    test_misaligned();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifu_fetch_ctrl.md
IFU_FETCH_CTRL -- requirements
Module: ifu_fetch_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning the width of the PC, address and instruction.
REQ-002 SHALL have parameter PC_RST, default 32'h8000_0000, meaning the fetch address after reset.
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of WAIT cycles before a fault is raised (range 1..255).
REQ-004 SHALL use one clock and a synchronous, active-low reset: clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous active-low reset; rst==0 at a rising edge resets the block.
REQ-006 imem_req_valid  output  1  fetch request valid.
REQ-007 imem_req_ready  input  1  memory accepts the request.
REQ-008 imem_req_addr  output  XLEN  fetch address, word aligned.
REQ-009 imem_resp_valid  input  1  response data valid.
REQ-010 imem_resp_data  input  XLEN  fetched instruction.
REQ-011 imem_resp_err  input  1  access error, qualified by imem_resp_valid.
REQ-012 out_valid  output  1  instruction available to decode.
REQ-013 out_ready  input  1  decode accepts the instruction.
REQ-014 out_pc  output  XLEN  PC of the delivered instruction.
REQ-015 out_instr  output  XLEN  delivered instruction word.
REQ-016 out_fault  output  1  delivered word is invalid because of an error or timeout.
REQ-017 upd_valid  input  1  writeback presents the next PC.
REQ-018 upd_pc  input  XLEN  next PC computed downstream.

Function
REQ-019 SHALL implement a four-state FSM: REQ, WAIT, OUT and NEXT.
REQ-020 REQ: imem_req_valid=1 and imem_req_addr={pc[XLEN-1:2],2'b00}; on imem_req_ready=1, go to WAIT and clear the timeout counter.
REQ-021 The request address SHALL stay stable while imem_req_valid=1 and imem_req_ready=0.
REQ-022 WAIT: on imem_resp_valid=1, latch out_instr=imem_resp_data and out_fault=imem_resp_err, then go to OUT.
REQ-023 WAIT without a response: increment the 8-bit counter each cycle.
REQ-024 When the counter reaches TIMEOUT while in WAIT, latch out_instr=32'h0000_0013 (nop) and out_fault=1, then go to OUT.
REQ-025 If a response arrives in the same cycle the timeout fires, the response SHALL win.
REQ-026 OUT: out_valid=1, out_pc=pc; out_pc, out_instr and out_fault SHALL stay stable until out_ready=1.
REQ-027 OUT: on out_ready=1, go to NEXT; out_valid drops the following cycle.
REQ-028 NEXT: on upd_valid=1, set pc=upd_pc and go to REQ.
REQ-029 upd_pc[1:0] SHALL be ignored for the address, but upd_pc SHALL be stored unchanged in pc.
REQ-030 The following SHALL be ignored and SHALL NOT change state: imem_resp_valid outside WAIT, upd_valid outside NEXT, and out_ready outside OUT.
REQ-031 Every state SHALL have a minimum residency of one cycle; minimum fetch-to-deliver latency is request accepted at cycle t, response at t+1, out_valid at t+2.
REQ-032 imem_req_valid and out_valid SHALL be registered outputs, never both 1 in the same cycle.
REQ-033 Illegal or unreachable state encodings SHALL go to REQ with pc unchanged.

Reset
REQ-034 When rst==0 at a rising edge, the block SHALL set state=REQ, pc=PC_RST, counter=0, out_instr=0 and out_fault=0.
REQ-035 In the first cycle after reset is released, imem_req_valid=1 with imem_req_addr=PC_RST, and out_valid=0.
REQ-036 Reset in any state, including WAIT with a request outstanding, SHALL abandon the fetch; the instruction memory shares the same reset and returns no stale response.

Verification
REQ-037 Reset release, req_ready=1, resp 1 cycle later with 32'h00100093, out_ready=1 -> out_valid at cycle 3, out_pc=0x80000000, out_instr=0x00100093, out_fault=0.
REQ-038 req_ready held low for 5 cycles -> imem_req_addr stays 0x80000000 and no WAIT entry; then resp arrives after 3 WAIT cycles -> delivered correctly.
REQ-039 out_ready low for 4 cycles in OUT with a random upd_valid and imem_resp_valid -> outputs stable, no state change; after out_ready, upd_valid with upd_pc=0x80000010 -> next request addr 0x80000010.
REQ-040 No response for TIMEOUT=255 cycles -> out_instr=0x00000013, out_fault=1; repeat with imem_resp_err=1 on the response -> out_fault=1 with resp data passed.
REQ-041 Assert rst=0 mid-WAIT and mid-OUT -> next cycle state REQ, imem_req_addr=0x80000000, out_valid=0.
REQ-042 upd_pc=0x80000006 -> imem_req_addr=0x80000004 and out_pc=0x80000006.
